mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter TIMEOUT, default 15: memory-wait limit in cycles, legal range 1..255.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high; sampled on rising edge of clk.
REQ-004 opcode  in  6  instruction[31:26] from the instruction register; valid in DECODE.
REQ-005 mem_ready  in  1  memory completion for current mem_read/mem_write.
REQ-006 pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write  out  1 each  PC and memory strobes/selects.
REQ-007 mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  register-file and ALU-A selects.
REQ-008 alu_src_b, alu_op, pc_source  out  2 each  ALU-B select, ALU class (00 add, 01 sub, 10 funct, 11 immediate-op), next-PC select.
REQ-009 ext_sel  out  1  immediate extender mode: 0 = sign-extend 16->32, 1 = zero-extend.
REQ-010 instr_done  out  1  combinational pulse in last cycle of each instruction.
REQ-011 illegal, mem_err  out  1 each  registered one-cycle error pulses.
REQ-012 state  out  4  current state encoding, for debug.

Function
REQ-013 States/encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11; 12-15 unreachable, next state FETCH.
REQ-014 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready; -> DECODE when mem_ready, else hold.
REQ-015 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00, ext_sel=0; opcode latched into op_q; next by opcode: 000000->R_EXEC, 100011/101011->MEM_ADDR, 000100->BRANCH, 000010->JUMP, 001000/001100/001101->I_EXEC, any other->FETCH with illegal=1 next cycle.
REQ-016 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00, ext_sel=0; -> MEM_READ if op_q=100011, else MEM_WRITE.
REQ-017 MEM_READ: mem_read=1, i_or_d=1; -> MEM_WB when mem_ready, else hold. MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1; -> FETCH.
REQ-018 MEM_WRITE: mem_write=1, i_or_d=1; instr_done=mem_ready; -> FETCH when mem_ready, else hold.
REQ-019 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; -> R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1; -> FETCH.
REQ-020 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1, instr_done=1; -> FETCH.
REQ-021 JUMP: pc_source=10, pc_write=1, instr_done=1; -> FETCH.
REQ-022 I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11; ext_sel=1 if op_q is 001100 or 001101, else 0; -> I_WB. I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, ext_sel held as in I_EXEC, instr_done=1; -> FETCH.
REQ-023 Any output not listed for a state is 0.
REQ-024 Wait counter wait_cnt (8 bit) increments each cycle in FETCH/MEM_READ/MEM_WRITE with mem_ready=0; clears on any state change.
REQ-025 wait_cnt==TIMEOUT with mem_ready=0: next state FETCH, no strobes completed, mem_err=1 next cycle for exactly one cycle.
REQ-026 mem_ready=1 in the same cycle as wait_cnt==TIMEOUT: normal completion, no mem_err.
REQ-027 Timeout in FETCH re-enters FETCH with wait_cnt cleared; PC unchanged.

Reset
REQ-028 reset=1 at a clock edge: state=FETCH, op_q=0, wait_cnt=0, illegal=0, mem_err=0, regardless of current state (including mid-stall).
REQ-029 While reset=1, mem_read, mem_write, pc_write, pc_write_cond, ir_write, reg_write, instr_done forced 0; first cycle after reset presents FETCH outputs.

Verification
REQ-030 lw (100011), mem_ready=1 always -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 in cycle 5; instr_done once.
REQ-031 sw (101011), mem_ready low 3 cycles in MEM_WRITE -> mem_write held 4 cycles, instr_done only in 4th, no register write.
REQ-032 ori (001101) then addi (001000) -> ext_sel=1 in I_EXEC/I_WB for ori, 0 for addi; alu_op=11 both.
REQ-033 opcode 111111 in DECODE -> next state FETCH, illegal=1 for one cycle, no reg_write/mem_write.
REQ-034 TIMEOUT=3, mem_ready held 0 in MEM_READ -> after 4 cycles state 0, mem_err pulses once; repeat with mem_ready=1 at wait_cnt=3 -> MEM_WB, no mem_err.
REQ-035 reset asserted during MEM_READ stall -> next cycle state 0, all strobes 0 during reset, mem_err/illegal 0.

Source files
------------

// File: rtl/mc_control.sv
// mc_control: multi-cycle processor control unit.
//
// Sequences each instruction through FETCH/DECODE and an opcode-specific
// execution path. It drives the datapath selects and strobes for every state.
// Memory waits in FETCH, MEM_READ and MEM_WRITE are bounded by TIMEOUT. When
// the bound is hit, the control unit abandons the access, returns to FETCH and
// raises mem_err.
//
// Ports
//   clk, reset             : clock, synchronous active-high reset
//   opcode[5:0]            : instruction[31:26], sampled in DECODE
//   mem_ready              : memory completion for the current access
//   pc_write, pc_write_cond: PC update strobes
//   i_or_d                 : memory address select (0 = PC, 1 = ALUOut)
//   mem_read, mem_write    : memory strobes
//   ir_write               : instruction register load
//   mem_to_reg, reg_dst    : register-file write-data / destination selects
//   reg_write              : register-file write strobe
//   alu_src_a, alu_src_b   : ALU operand selects
//   alu_op                 : ALU class (00 add, 01 sub, 10 funct, 11 imm-op)
//   pc_source              : next-PC select
//   ext_sel                : immediate extension (0 sign, 1 zero)
//   instr_done             : last cycle of an instruction (combinational)
//   illegal, mem_err       : registered one-cycle error pulses
//   state[3:0]             : current state, for debug

module mc_control #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       ext_sel,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic [5:0] op_q;
    logic [7:0] wait_cnt;
    logic       illegal_d;
    logic       waiting;
    logic       timeout;
    logic       imm_zext;

    // A memory wait is in progress only in the three access states while the
    // memory has not answered; mem_ready in the limit cycle still completes.
    assign waiting  = ((state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                       (state_q == S_MEM_WRITE)) && !mem_ready;
    assign timeout  = waiting && (wait_cnt == TMO);
    assign imm_zext = (op_q == OP_ANDI) || (op_q == OP_ORI);
    assign state    = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            op_q     <= '0;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            illegal <= illegal_d;
            mem_err <= timeout;
            if (state_q == S_DECODE)
                op_q <= opcode;
            // A FETCH timeout keeps the state, so the counter is cleared
            // explicitly rather than relying on the state change.
            if (timeout || (state_d != state_q))
                wait_cnt <= '0;
            else if (waiting)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_comb begin
        state_d       = S_FETCH;
        illegal_d     = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        ext_sel       = 1'b0;
        instr_done    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:               state_d = S_R_EXEC;
                    OP_LW, OP_SW:           state_d = S_MEM_ADDR;
                    OP_BEQ:                 state_d = S_BRANCH;
                    OP_J:                   state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_I_EXEC;
                    default:                illegal_d = 1'b1;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready)
                    state_d = S_MEM_WB;
                else if (!timeout)
                    state_d = S_MEM_READ;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
                state_d    = (mem_ready || timeout) ? S_FETCH : S_MEM_WRITE;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_source     = 2'b01;
                pc_write_cond = 1'b1;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_source  = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
                ext_sel   = imm_zext;
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                ext_sel    = imm_zext;
                instr_done = 1'b1;
            end
            default: ;
        endcase

        // No side-effecting strobe may escape while reset is held.
        if (reset) begin
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            instr_done    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

    localparam int TMO = 3;

    localparam logic [5:0] LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, JMP = 6'h02;
    localparam logic [5:0] ADDI = 6'h08, ANDI = 6'h0C, ORI = 6'h0D, RTY = 6'h00;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       ext_sel, instr_done, illegal, mem_err;
    logic [3:0] state;

    mc_control #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .ext_sel(ext_sel), .instr_done(instr_done),
        .illegal(illegal), .mem_err(mem_err), .state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    // Behavioural model: the current step of the instruction plus a queue of
    // the steps still to come, chosen from the opcode at decode.
    int   m_phase = 0;
    int   m_seq[$];
    logic [5:0] m_op = 6'h00;
    int   m_wait = 0;
    logic m_ill = 1'b0;
    logic m_err = 1'b0;

    function automatic bit is_wait_step(int p);
        return (p == 0) || (p == 3) || (p == 5);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_seq.delete(); m_op = 6'h00; m_wait = 0;
            m_ill = 1'b0; m_err = 1'b0;
        end else begin
            m_ill = 1'b0;
            m_err = 1'b0;
            if (is_wait_step(m_phase) && !mem_ready) begin
                if (m_wait == TMO) begin
                    m_phase = 0; m_seq.delete(); m_wait = 0; m_err = 1'b1;
                end else begin
                    m_wait++;
                end
            end else begin
                m_wait = 0;
                if (m_phase == 0) begin
                    m_phase = 1;
                end else if (m_phase == 1) begin
                    m_op = opcode;
                    m_seq.delete();
                    case (opcode)
                        RTY:            begin m_seq.push_back(6); m_seq.push_back(7); end
                        LW:             begin m_seq.push_back(2); m_seq.push_back(3); m_seq.push_back(4); end
                        SW:             begin m_seq.push_back(2); m_seq.push_back(5); end
                        BEQ:            m_seq.push_back(8);
                        JMP:            m_seq.push_back(9);
                        ADDI, ANDI, ORI: begin m_seq.push_back(10); m_seq.push_back(11); end
                        default:        m_ill = 1'b1;
                    endcase
                    m_phase = (m_seq.size() > 0) ? m_seq.pop_front() : 0;
                end else begin
                    m_phase = (m_seq.size() > 0) ? m_seq.pop_front() : 0;
                end
            end
        end
    end

    function automatic logic [23:0] model_vec();
        int p;
        logic g, ew, pcw, pcc, iod, mr, mw, irw, mtr, rd, rw, asa, ext, done;
        logic [1:0] asb, aop, pcs;
        p    = m_phase;
        g    = !reset;
        pcw  = g && ((p == 0 && mem_ready) || p == 9);
        pcc  = g && (p == 8);
        iod  = (p == 3) || (p == 5);
        mr   = g && ((p == 0) || (p == 3));
        mw   = g && (p == 5);
        irw  = g && (p == 0) && mem_ready;
        mtr  = (p == 4);
        rd   = (p == 7);
        rw   = g && ((p == 4) || (p == 7) || (p == 11));
        asa  = (p == 2) || (p == 6) || (p == 8) || (p == 10);
        asb  = (p == 0) ? 2'd1 : (p == 1) ? 2'd3 : ((p == 2) || (p == 10)) ? 2'd2 : 2'd0;
        aop  = (p == 6) ? 2'd2 : (p == 8) ? 2'd1 : (p == 10) ? 2'd3 : 2'd0;
        pcs  = (p == 8) ? 2'd1 : (p == 9) ? 2'd2 : 2'd0;
        ew   = (m_op == ANDI) || (m_op == ORI);
        ext  = ((p == 10) || (p == 11)) && ew;
        done = g && ((p == 4) || (p == 7) || (p == 8) || (p == 9) || (p == 11) ||
                     ((p == 5) && mem_ready));
        return {pcw, pcc, iod, mr, mw, irw, mtr, rd, rw, asa, asb, aop, pcs,
                ext, done, m_ill, m_err, 4'(p)};
    endfunction

    wire [23:0] dut_vec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                           ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                           alu_src_b, alu_op, pc_source, ext_sel, instr_done,
                           illegal, mem_err, state};

    always @(negedge clk) begin
        if (chk_en) begin
            logic [23:0] exp_v;
            exp_v = model_vec();
            n_checks++;
            if (dut_vec !== exp_v) begin
                n_errors++;
                $display("FAIL outputs t=%0t actual=%h expected=%h (state %0d op %h rdy %b rst %b)",
                         $time, dut_vec, exp_v, m_phase, opcode, mem_ready, reset);
            end
        end
    end

    task automatic tick(input logic r, input logic [5:0] op, input logic rdy);
        @(posedge clk);
        #1;
        reset = r; opcode = op; mem_ready = rdy;
        #1;
    endtask

    task automatic lit(input string name, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp_v, $time);
        end
    endtask

    initial begin
        int cnt_done, cnt_mw, cnt_rw;
        int lw_st[5]  = '{0, 1, 2, 3, 4};
        int sw_st[7]  = '{0, 1, 2, 5, 5, 5, 5};
        logic sw_rdy[7] = '{1, 1, 1, 0, 0, 0, 1};
        int to_st[7]  = '{0, 1, 2, 3, 3, 3, 3};
        logic to_rdy[7] = '{1, 1, 1, 0, 0, 0, 0};
        int ok_st[8]  = '{0, 1, 2, 3, 3, 3, 3, 4};
        logic ok_rdy[8] = '{1, 1, 1, 0, 0, 0, 1, 1};
        int i_st[4]   = '{0, 1, 10, 11};
        logic [5:0] ops[8] = '{RTY, LW, SW, BEQ, JMP, ADDI, ANDI, ORI};

        // Reset
        tick(1, 6'h00, 0);
        tick(1, 6'h00, 0);
        chk_en = 1'b1;
        lit("reset_state", state, 0);
        lit("reset_mem_read", mem_read, 0);
        lit("reset_illegal", illegal, 0);
        lit("reset_mem_err", mem_err, 0);

        // lw, memory always ready
        cnt_done = 0;
        for (int i = 0; i < 5; i++) begin
            tick(0, LW, 1);
            lit("lw_state", state, lw_st[i]);
            cnt_done += instr_done;
            if (i == 4) begin
                lit("lw_reg_write", reg_write, 1);
                lit("lw_mem_to_reg", mem_to_reg, 1);
            end
        end
        lit("lw_done_once", cnt_done, 1);

        // sw with three stall cycles in MEM_WRITE, completing at the limit
        cnt_done = 0; cnt_mw = 0; cnt_rw = 0;
        for (int i = 0; i < 7; i++) begin
            tick(0, SW, sw_rdy[i]);
            lit("sw_state", state, sw_st[i]);
            cnt_mw += mem_write; cnt_rw += reg_write;
            if (i >= 3) lit("sw_done", instr_done, (i == 6) ? 1 : 0);
        end
        lit("sw_mem_write_cycles", cnt_mw, 4);
        lit("sw_no_reg_write", cnt_rw, 0);
        tick(0, SW, 0);
        lit("sw_no_mem_err", mem_err, 0);
        lit("sw_back_fetch", state, 0);

        // ori then addi
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                tick(0, (k == 0) ? ORI : ADDI, 1);
                lit("imm_state", state, i_st[i]);
                if (i >= 2) begin
                    lit((k == 0) ? "ori_ext_sel" : "addi_ext_sel", ext_sel, (k == 0) ? 1 : 0);
                    if (i == 2) lit("imm_alu_op", alu_op, 3);
                end
            end
        end

        // illegal opcode
        tick(0, 6'h3F, 1);
        tick(0, 6'h3F, 1);
        lit("ill_decode", state, 1);
        tick(0, 6'h3F, 0);
        lit("ill_state", state, 0);
        lit("ill_pulse", illegal, 1);
        lit("ill_no_reg_write", reg_write, 0);
        tick(0, 6'h3F, 0);
        lit("ill_pulse_end", illegal, 0);

        // MEM_READ timeout
        for (int i = 0; i < 7; i++) begin
            tick(0, LW, to_rdy[i]);
            lit("to_state", state, to_st[i]);
        end
        tick(0, LW, 0);
        lit("to_back_fetch", state, 0);
        lit("to_mem_err", mem_err, 1);
        tick(0, LW, 0);
        lit("to_mem_err_end", mem_err, 0);

        // completion in the limit cycle
        for (int i = 0; i < 8; i++) begin
            tick(0, LW, ok_rdy[i]);
            lit("lim_state", state, ok_st[i]);
            if (i == 7) lit("lim_no_mem_err", mem_err, 0);
        end

        // FETCH timeout re-enters FETCH
        for (int i = 0; i < 4; i++) tick(0, LW, 0);
        tick(0, LW, 0);
        lit("fetch_to_state", state, 0);
        lit("fetch_to_mem_err", mem_err, 1);
        lit("fetch_to_pc_write", pc_write, 0);

        // reset during MEM_READ stall
        tick(0, LW, 1);
        tick(0, LW, 1);
        tick(0, LW, 0);
        tick(0, LW, 0);
        tick(0, LW, 0);
        lit("rst_stall_state", state, 3);
        tick(1, LW, 0);
        lit("rst_forced_mem_read", mem_read, 0);
        lit("rst_forced_done", instr_done, 0);
        tick(0, LW, 1);
        lit("rst_after_state", state, 0);
        lit("rst_after_mem_err", mem_err, 0);
        lit("rst_after_mem_read", mem_read, 1);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            logic r, rdy;
            logic [5:0] op;
            r   = ($urandom_range(0, 199) == 0);
            rdy = ($urandom_range(0, 99) < 60);
            op  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            tick(r, op, rdy);
        end

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
